// File: rtl/clock_module_root.sv
// Root responder of the clock-tree request protocol.
// Answers one child's request with a timed start/stop handshake and gates the
// raw root clock onto the tree through a glitch-free latch-based clock gate.
`timescale 1ns/1ps
module clock_module_root #(
  parameter int START_CYCLES   = 8,
  parameter int STOP_CYCLES    = 4,
  parameter int MIN_OFF_CYCLES = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clock,
  input  logic             async_resetn,
  input  logic             child_request,
  output logic             child_ready,
  output logic             child_silent,
  output logic             child_starting,
  output logic             child_stopping,
  input  logic             clock_route_path_in,
  output logic             clock_route_path_out,
  output logic [CNT_W-1:0] start_count
);

  // Sequence counter only ever holds START_CYCLES-1 or STOP_CYCLES-1 at most.
  localparam int SEQ_MAX = (START_CYCLES > STOP_CYCLES) ? START_CYCLES : STOP_CYCLES;
  localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
  localparam int OFF_W   = (MIN_OFF_CYCLES > 0) ? $clog2(MIN_OFF_CYCLES + 1) : 1;

  localparam logic [SEQ_W-1:0] START_LOAD = SEQ_W'(START_CYCLES - 1);
  localparam logic [SEQ_W-1:0] STOP_LOAD  = SEQ_W'(STOP_CYCLES - 1);
  localparam logic [OFF_W-1:0] OFF_LOAD   = OFF_W'(MIN_OFF_CYCLES);

  // One-hot encoding: each status output is a single state-register bit,
  // so the outputs are registered and mutually exclusive by construction.
  typedef enum logic [3:0] {
    SILENT   = 4'b0001,
    STARTING = 4'b0010,
    READY    = 4'b0100,
    STOPPING = 4'b1000
  } state_t;

  state_t             state_q,       state_d;
  logic [SEQ_W-1:0]   seq_cnt_q,     seq_cnt_d;
  logic [OFF_W-1:0]   off_cnt_q,     off_cnt_d;
  logic               gate_en_q,     gate_en_d;
  logic [CNT_W-1:0]   start_count_q, start_count_d;
  logic               gate_en_lat;

  // Saturating increment: the statistic sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, counter and gate-enable logic for the start/stop handshake.
  always_comb begin
    state_d       = state_q;
    seq_cnt_d     = seq_cnt_q;
    off_cnt_d     = off_cnt_q;
    gate_en_d     = gate_en_q;
    start_count_d = start_count_q;
    case (state_q)
      SILENT: begin
        if (off_cnt_q != '0) begin
          off_cnt_d = off_cnt_q - OFF_W'(1);
        end else if (child_request) begin
          state_d   = STARTING;
          gate_en_d = 1'b1;
          seq_cnt_d = START_LOAD;
        end
      end
      STARTING: begin
        // Never aborted; a dropped request is seen once READY is reached.
        if (seq_cnt_q == '0) begin
          state_d       = READY;
          start_count_d = sat_inc(start_count_q);
        end else begin
          seq_cnt_d = seq_cnt_q - SEQ_W'(1);
        end
      end
      READY: begin
        if (!child_request) begin
          state_d   = STOPPING;
          gate_en_d = 1'b0;
          seq_cnt_d = STOP_LOAD;
        end
      end
      STOPPING: begin
        // Never aborted; a new request is seen once SILENT is reached.
        if (seq_cnt_q == '0) begin
          state_d   = SILENT;
          off_cnt_d = OFF_LOAD;
        end else begin
          seq_cnt_d = seq_cnt_q - SEQ_W'(1);
        end
      end
      default: begin
        state_d   = SILENT;
        gate_en_d = 1'b0;
      end
    endcase
  end

  // Control state register with asynchronous return to the silent state.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state_q       <= SILENT;
      seq_cnt_q     <= '0;
      off_cnt_q     <= '0;
      gate_en_q     <= 1'b0;
      start_count_q <= '0;
    end else begin
      state_q       <= state_d;
      seq_cnt_q     <= seq_cnt_d;
      off_cnt_q     <= off_cnt_d;
      gate_en_q     <= gate_en_d;
      start_count_q <= start_count_d;
    end
  end

  // ICG latch: follows the enable only while the raw clock is low, so the gate
  // can never open or close in the middle of a high phase. Reset forces it shut.
  always_latch begin
    if (!async_resetn) begin
      gate_en_lat = 1'b0;
    end else if (!clock_route_path_in) begin
      gate_en_lat = gate_en_q;
    end
  end

  assign clock_route_path_out = clock_route_path_in & gate_en_lat;

  assign child_silent   = state_q[0];
  assign child_starting = state_q[1];
  assign child_ready    = state_q[2];
  assign child_stopping = state_q[3];
  assign start_count    = start_count_q;

endmodule

// File: tb/tb_clock_module_root.sv
// Scoreboard bench for clock_module_root: the driver pushes hand-computed
// status transitions (cycle, status, start_count); a negedge monitor pops and
// compares them whenever the status outputs change.
`timescale 1ns/1ps
module tb_clock_module_root;

  localparam int TB_CNT_W = 2;
  localparam logic [3:0] SIL = 4'b0001;
  localparam logic [3:0] STA = 4'b0010;
  localparam logic [3:0] RDY = 4'b0100;
  localparam logic [3:0] STP = 4'b1000;

  logic                clock = 1'b0;
  logic                async_resetn = 1'b1;
  logic                child_request = 1'b0;
  logic                child_ready, child_silent, child_starting, child_stopping;
  logic                clock_route_path_in = 1'b0;
  logic                clock_route_path_out;
  logic [TB_CNT_W-1:0] start_count;

  typedef struct {
    int                  cyc;
    logic [3:0]          st;
    logic [TB_CNT_W-1:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pulses = 0;
  bit         mon_en = 1'b0;
  logic [3:0] prev_st = SIL;
  realtime    t_rise = 0.0;
  bit         rise_seen = 1'b0;

  clock_module_root #(
    .START_CYCLES  (8),
    .STOP_CYCLES   (4),
    .MIN_OFF_CYCLES(2),
    .CNT_W         (TB_CNT_W)
  ) dut (
    .clock               (clock),
    .async_resetn        (async_resetn),
    .child_request       (child_request),
    .child_ready         (child_ready),
    .child_silent        (child_silent),
    .child_starting      (child_starting),
    .child_stopping      (child_stopping),
    .clock_route_path_in (clock_route_path_in),
    .clock_route_path_out(clock_route_path_out),
    .start_count         (start_count)
  );

  // Control clock period 20; raw root clock period 2, offset so edges never coincide.
  always #10 clock = ~clock;
  initial begin
    #0.5;
    forever #1 clock_route_path_in = ~clock_route_path_in;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input int c, input logic [3:0] s, input logic [TB_CNT_W-1:0] n);
    exp_t e;
    e.cyc = c;
    e.st  = s;
    e.cnt = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: per-cycle one-hot and gate-level checks, plus scoreboard compare on status change.
  always @(negedge clock) begin
    if (mon_en) begin
      logic [3:0] v;
      v = {child_stopping, child_ready, child_starting, child_silent};
      checks++;
      if (!$onehot(v)) begin
        errors++;
        $display("FAIL onehot: got %b at cycle %0d", v, cyc);
      end
      checks++;
      if (clock_route_path_out !== (child_starting | child_ready)) begin
        errors++;
        $display("FAIL gate_level: got %b expected %b at cycle %0d",
                 clock_route_path_out, (child_starting | child_ready), cyc);
      end
      if (v !== prev_st) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transition: got status %b count %0d at cycle %0d, none expected",
                   v, start_count, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (v !== e.st || cyc != e.cyc || start_count !== e.cnt) begin
            errors++;
            $display("FAIL transition: got status %b cycle %0d count %0d, expected status %b cycle %0d count %0d",
                     v, cyc, start_count, e.st, e.cyc, e.cnt);
          end
        end
      end
      prev_st = v;
    end
  end

  // Every gated high pulse must be a full raw high phase (1 ns).
  always @(posedge clock_route_path_out) begin
    t_rise    = $realtime;
    rise_seen = 1'b1;
  end
  always @(negedge clock_route_path_out) begin
    if (rise_seen) begin
      realtime w;
      w = $realtime - t_rise;
      checks++;
      pulses++;
      if (w < 0.99 || w > 1.01) begin
        errors++;
        $display("FAIL pulse_width: got %0.3f ns expected 1.000 ns at t=%0t", w, $time);
      end
      rise_seen = 1'b0;
    end
  end

  initial begin
    int n;
    // T1: reset state
    #1 async_resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_silent",   child_silent,         1);
    chk("rst_ready",    child_ready,          0);
    chk("rst_starting", child_starting,       0);
    chk("rst_stopping", child_stopping,       0);
    chk("rst_count",    start_count,          0);
    #1;
    chk("rst_gate_out", clock_route_path_out, 0);
    #2 async_resetn = 1'b1;
    prev_st = SIL;
    mon_en  = 1'b1;
    @(posedge clock);
    #1;

    // T2: plain start then stop
    n = cyc;
    child_request = 1'b1;
    push(n + 1, STA, 0);
    push(n + 9, RDY, 1);
    wait_cyc(n + 12);
    n = cyc;
    child_request = 1'b0;
    push(n + 1, STP, 1);
    push(n + 5, SIL, 1);
    wait_cyc(n + 8);

    // T3: restart, then a one-cycle request glitch in READY
    n = cyc;
    child_request = 1'b1;
    push(n + 1, STA, 1);
    push(n + 9, RDY, 2);
    wait_cyc(n + 12);
    n = cyc;
    child_request = 1'b0;
    wait_cyc(n + 1);
    child_request = 1'b1;
    push(n + 1,  STP, 2);
    push(n + 5,  SIL, 2);
    push(n + 8,  STA, 2);
    push(n + 16, RDY, 3);
    wait_cyc(n + 18);
    chk("count_after_glitch", start_count, 3);

    // T4: drop during STARTING, toggle during STOPPING, count saturates at 3
    n = cyc;
    child_request = 1'b0;
    push(n + 1, STP, 3);
    push(n + 5, SIL, 3);
    wait_cyc(n + 9);
    n = cyc;
    child_request = 1'b1;
    push(n + 1,  STA, 3);
    push(n + 9,  RDY, 3);
    push(n + 10, STP, 3);
    push(n + 14, SIL, 3);
    wait_cyc(n + 3);
    child_request = 1'b0;
    wait_cyc(n + 11);
    child_request = 1'b1;
    wait_cyc(n + 12);
    child_request = 1'b0;
    wait_cyc(n + 18);
    chk("count_saturated", start_count, 3);

    // T5: reset pulse mid-STARTING, immediate restart with no off hold
    n = cyc;
    child_request = 1'b1;
    push(n + 1, STA, 3);
    wait_cyc(n + 4);
    push(n + 4, SIL, 0);
    push(n + 5, STA, 0);
    push(n + 13, RDY, 1);
    async_resetn = 1'b0;
    #1;
    chk("midrst_silent",   child_silent,         1);
    chk("midrst_starting", child_starting,       0);
    chk("midrst_gate_out", clock_route_path_out, 0);
    chk("midrst_count",    start_count,          0);
    #2 async_resetn = 1'b1;
    wait_cyc(n + 16);
    n = cyc;
    child_request = 1'b0;
    push(n + 1, STP, 1);
    push(n + 5, SIL, 1);
    wait_cyc(n + 8);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_transition: got nothing, expected status %b at cycle %0d", e.st, e.cyc);
    end
    checks++;
    if (pulses < 10) begin
      errors++;
      $display("FAIL gated_pulses: got %0d expected at least 10", pulses);
    end
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
